// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: op codes and FSM states.
package shift_pkg;

    localparam int unsigned OP_W = 2;
    localparam int unsigned ST_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_SLL = 2'b00,
        OP_ROL = 2'b01,
        OP_SLA = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit left step for SLL / ROL / SLA.
// ROL is only built when SEQ_SHIFT_ROTATE_EN is defined; otherwise it falls back to SLL.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] r,
    input  op_e              op,
    output logic [WIDTH-1:0] next_r,
    output logic             ovf_bit
);

    always_comb begin
        next_r  = {r[WIDTH-2:0], 1'b0};
        ovf_bit = 1'b0;
        case (op)
`ifdef SEQ_SHIFT_ROTATE_EN
            OP_ROL:  next_r = {r[WIDTH-2:0], r[WIDTH-1]};
`endif
            // Sign change on this step means the signed value no longer fits.
            OP_SLA:  ovf_bit = r[WIDTH-1] ^ r[WIDTH-2];
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_left_shifter.sv
// Iterative left shifter: one bit per clock behind a start/done handshake.
// Optional rotate support is selected with SEQ_SHIFT_ROTATE_EN.
module seq_left_shifter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   b,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    state_e             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   r_q, r_d;
    op_e                op_q, op_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   step_r;
    logic               step_ovf;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r       (r_q),
        .op      (op_q),
        .next_r  (step_r),
        .ovf_bit (step_ovf)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        op_d    = op_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    r_d     = a;
                    cnt_d   = b;
                    op_d    = op_e'(op);
                    ovf_d   = 1'b0;
                    state_d = (b != SHW'(0)) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                r_d   = step_r;
                ovf_d = ovf_q | step_ovf;
                cnt_d = cnt_q - SHW'(1);
                // Counter at 1 means this is the final step.
                if (cnt_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            op_q    <= OP_SLL;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = r_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_seq_left_shifter.sv
// Directed self-checking bench for seq_left_shifter (WIDTH=8).
module tb_seq_left_shifter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SHW   = 3;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   b;
    logic [1:0]       op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;

    int n_checks;
    int n_fail;

    seq_left_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .op     (op),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure edges until done, then verify outputs and hold.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [2:0] bv,
                          input logic [1:0] opv, input int exp_lat,
                          input logic [7:0] exp_res, input logic exp_ovf);
        int lat;
        a     = av;
        b     = bv;
        op    = opv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_held"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        logic [7:0] rol_exp;
        int         seen_done;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        op       = 2'b00;

`ifdef SEQ_SHIFT_ROTATE_EN
        rol_exp = 8'h03;
`else
        rol_exp = 8'h02;
`endif

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back ops: each starts in the IDLE cycle right after DONE.
        run_op("sll_81_1", 8'h81, 3'd1, 2'b00, 2, 8'h02, 1'b0);
        run_op("rol_81_1", 8'h81, 3'd1, 2'b01, 2, rol_exp, 1'b0);
        run_op("sla_40_1", 8'h40, 3'd1, 2'b10, 2, 8'h80, 1'b1);
        run_op("sla_f0_3", 8'hF0, 3'd3, 2'b10, 4, 8'h80, 1'b0);
        run_op("b0_5a", 8'h5A, 3'd0, 2'b00, 1, 8'h5A, 1'b0);
        run_op("rsv_81_2", 8'h81, 3'd2, 2'b11, 3, 8'h04, 1'b0);
        run_op("sla_60_3", 8'h60, 3'd3, 2'b10, 4, 8'h00, 1'b1);
        run_op("sll_01_7", 8'h01, 3'd7, 2'b00, 8, 8'h80, 1'b0);

        // Long op interrupted by an ignored start and then an async reset.
        a     = 8'h01;
        b     = 3'd7;
        op    = 2'b00;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("long_latched", 32'(result), 32'h01);
        check("long_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        a     = 8'hFF;
        b     = 3'd0;
        op    = 2'b10;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("ign_start_busy", 32'(busy), 32'd1);
        check("ign_start_done", 32'(done), 32'd0);
        check("ign_start_result", 32'(result), 32'h08);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen_done++;
        end
        check("no_done_after_rst", 32'(seen_done), 32'd0);
        check("idle_after_rst", 32'(busy), 32'd0);

        run_op("sla_c0_2", 8'hC0, 3'd2, 2'b10, 3, 8'h00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_left_shifter.md
# seq_left_shifter

Iterative left-shift unit that shifts an operand one bit per clock under a start/done handshake. It is the left-direction counterpart of the team's combinational right-shift datapath and sits beside it in the ALU cluster. It trades latency for area on multi-cycle ops and supports logical shift, rotate, and arithmetic shift with overflow detect.

## Interface
- `WIDTH`, default 8: operand/result width in bits, at least 2.
- `SHW`, default 3: shift-amount width; `$clog2(WIDTH)`.
- `clk` in, 1 bit: single clock, rising edge.
- `reset` in, 1 bit: asynchronous, active-high reset.
- `start` in, 1 bit: request pulse; sampled only in IDLE.
- `a` in, WIDTH bits: operand, latched on accepted start.
- `b` in, SHW bits: unsigned shift amount, latched on accepted start.
- `op` in, 2 bits: 00 SLL, 01 ROL, 10 SLA, 11 reserved (executes as SLL).
- `busy` out, 1 bit: high from the cycle after an accepted start through the DONE cycle.
- `done` out, 1 bit: one-cycle pulse when `result`/`ovf` are valid.
- `result` out, WIDTH bits: shifted value, held until the next accepted start.
- `ovf` out, 1 bit: SLA signed overflow, sticky per op; always 0 for SLL/ROL.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE with `start`=1:
  - Latch `a` into the working register, `b` into the counter and `op` into the op register.
  - Clear `ovf`.
  - Go to SHIFT if `b`≠0, else to DONE.
- IDLE with `start`=0: stay in IDLE.
- SHIFT, once per cycle:
  - Apply one 1-bit step and decrement the counter.
  - When the counter reaches 1 before the step, go to DONE after that step.
- 1-bit step:
  - SLL: `{r[W-2:0],0}`.
  - ROL: `{r[W-2:0],r[W-1]}`.
  - SLA: same shift as SLL, and `ovf |= r[W-1]^r[W-2]`, evaluated before the shift.
- DONE: `done`=1 and `result` equals the working register. Go to IDLE the next cycle.
- `start` asserted outside IDLE is ignored and not queued.
- Widths: the counter is SHW bits. With SHW=3 the full range `b`=0..7 is legal. There is no modulo beyond SHW.
- Reset, asynchronous and effective at any point including mid-SHIFT:
  - state=IDLE, `busy`=0, `done`=0, `result`=0, `ovf`=0, counter=0.
  - The in-flight op is discarded with no `done`.

## Timing
- Start accepted at edge 0.
- `done` is high in cycle b+1 after the accepting edge; for `b`=0 it is high 1 cycle after.
- Back-to-back throughput: one op per b+2 cycles. The earliest next start is sampled in the IDLE cycle after DONE.
- `result` and `ovf` are registered outputs:
  - During SHIFT they show intermediate values.
  - They are valid only when `done`=1 and remain stable until the next accepted start.
- `busy` is registered and equals (state≠IDLE).

## Configuration
- `SEQ_SHIFT_ROTATE_EN` defined: op 01 performs ROL as specified.
- `SEQ_SHIFT_ROTATE_EN` not defined:
  - ROL logic is not compiled and op 01 executes as SLL.
  - Result and timing are identical to SLL.

## Structure
- Package `shift_pkg` holds:
  - The op encoding as an enum: `OP_SLL`, `OP_ROL`, `OP_SLA`, `OP_RSV`.
  - The FSM state enum: `ST_IDLE`, `ST_SHIFT`, `ST_DONE`.
- Sub-module `shift_step`: purely combinational 1-bit step.
  - Inputs: r, op.
  - Outputs: next_r, ovf_bit.
- The top level holds the FSM, counter and registers.

## Test plan
All with WIDTH=8.
- SLL, `a`=8'h81, `b`=1 -> `done` 2 cycles after the start edge, `result`=8'h02, `ovf`=0.
- ROL, `a`=8'h81, `b`=1 -> `result`=8'h03.
  - Without `SEQ_SHIFT_ROTATE_EN`: `result`=8'h02.
- SLA, `a`=8'h40, `b`=1 -> `result`=8'h80, `ovf`=1.
- SLA, `a`=8'hF0, `b`=3 -> `result`=8'h80, `ovf`=0, with `done` 4 cycles after start.
- `b`=0, `a`=8'h5A -> `done` after 1 cycle, `result`=8'h5A.
- Start op with `b`=7, then:
  - Pulse `start` at cycle 3 -> the pulse is ignored.
  - Assert `reset` at cycle 4 -> `busy`=0, `result`=0 and no `done` pulse.
